// File: rtl/onehot_drain_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : onehot_drain_encoder                                         |
// | Description : Accepts an N-bit request vector and emits one code per set   |
// |               bit (bit index + 1), or a single code 0 for an empty vector. |
// |               Lowest-index-first by default; round-robin selection with a  |
// |               persistent last-grant pointer when ONEHOT_DRAIN_RR_EN is     |
// |               defined.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module onehot_drain_encoder #(
   parameter int N  = 15,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [N-1:0]  in_req,
   output logic          in_ready,
   output logic          out_valid,
   output logic [CW-1:0] out_code,
   output logic          out_last,
   output logic          out_multi,
   input  logic          out_ready
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   state_t        state, state_n;
   logic [N-1:0]  pending, pending_n;
   logic [CW-1:0] code_n;
   logic          last_n;
   logic          multi_n;

   logic [N-1:0]  sel_vec;
   logic [N-1:0]  sel_bit;
   logic [N-1:0]  remaining;
   logic [CW-1:0] sel_idx;
   logic          accept;
   logic          advance;
   logic          grant;
   logic          multi_in;

   // Index of the lowest set bit of v (0 when v is empty; callers qualify).
   function automatic logic [CW-1:0] lowest_idx(input logic [N-1:0] v);
      logic [CW-1:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) r = CW'(i);
      end
      return r;
   endfunction

   assign out_valid = (state == DRAIN);
   assign in_ready  = (pending == '0) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign advance   = out_valid && out_ready && (pending != '0);
   assign grant     = (accept && (in_req != '0)) || advance;
   assign multi_in  = ((in_req & (in_req - ONE_N)) != '0);

   // While bits are pending they are the only candidates; otherwise the
   // incoming vector is searched so a reload costs no bubble.
   assign sel_vec = (pending != '0) ? pending : in_req;

`ifdef ONEHOT_DRAIN_RR_EN
   logic [CW-1:0] rr_ptr, rr_ptr_n;
   logic [N-1:0]  above_mask;
   logic [N-1:0]  above_vec;

   // Bits strictly above the last grant get first claim; otherwise wrap to 0.
   always_comb begin
      above_mask = '0;
      for (int i = 0; i < N; i++) begin
         above_mask[i] = (CW'(i) > rr_ptr);
      end
   end

   assign above_vec = sel_vec & above_mask;
   assign sel_idx   = (above_vec != '0) ? lowest_idx(above_vec) : lowest_idx(sel_vec);

   // Pointer follows every real grant; an empty vector leaves it untouched.
   always_comb begin
      rr_ptr_n = rr_ptr;
      if (grant) rr_ptr_n = sel_idx;
   end

   // Last-grant pointer register; reset value makes the first search start at bit 0.
   always_ff @(posedge clk) begin
      if (rst) rr_ptr <= CW'(N - 1);
      else     rr_ptr <= rr_ptr_n;
   end
`else
   assign sel_idx = lowest_idx(sel_vec);
`endif

   assign sel_bit   = ONE_N << sel_idx;
   assign remaining = sel_vec & ~sel_bit;

   // Next-state and next-output decode for the drain FSM.
   always_comb begin
      state_n   = state;
      pending_n = pending;
      code_n    = out_code;
      last_n    = out_last;
      multi_n   = out_multi;
      if (accept) begin
         state_n = DRAIN;
         if (in_req != '0) begin
            code_n    = sel_idx + CW'(1);
            pending_n = remaining;
            last_n    = (remaining == '0);
            multi_n   = multi_in;
         end else begin
            code_n    = '0;
            pending_n = '0;
            last_n    = 1'b1;
            multi_n   = 1'b0;
         end
      end else if (advance) begin
         code_n    = sel_idx + CW'(1);
         pending_n = remaining;
         last_n    = (remaining == '0);
      end else if (out_valid && out_ready) begin
         state_n = IDLE;
         last_n  = 1'b0;
      end
   end

   // State and output registers; outputs hold whenever nothing advances.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pending   <= '0;
         out_code  <= '0;
         out_last  <= 1'b0;
         out_multi <= 1'b0;
      end else begin
         state     <= state_n;
         pending   <= pending_n;
         out_code  <= code_n;
         out_last  <= last_n;
         out_multi <= multi_n;
      end
   end

endmodule
`default_nettype wire

// File: doc/onehot_drain_encoder.md
ONEHOT_DRAIN_ENCODER -- requirements
Module: onehot_drain_encoder

Interface
REQ-001 SHALL have parameter N, default 15, number of request bits (2..64).
REQ-002 SHALL have parameter CW, default $clog2(N+1), code width (4 at N=15).
REQ-003 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request vector offered.
REQ-006 SHALL have port in_req  input  N  request vector, any number of bits set.
REQ-007 SHALL have port in_ready  output  1  block accepts in_req this cycle.
REQ-008 SHALL have port out_valid  output  1  out_code valid.
REQ-009 SHALL have port out_code  output  CW  bit index + 1 of granted bit; 0 = empty vector.
REQ-010 SHALL have port out_last  output  1  final code of the current vector.
REQ-011 SHALL have port out_multi  output  1  accepted vector had more than one bit set.
REQ-012 SHALL have port out_ready  input  1  consumer takes out_code this cycle.

Function
REQ-013 SHALL hold state IDLE (no pending bits, out_valid=0) or DRAIN (out_valid=1).
REQ-014 SHALL keep an internal N-bit pending mask of not-yet-emitted request bits.
REQ-015 SHALL drive in_ready = (pending==0) and (out_valid==0 or out_ready==1), combinationally.
REQ-016 SHALL accept when in_valid and in_ready; out_valid/out_code appear the next cycle (latency 1).
REQ-017 On accept with in_req!=0: select one bit per REQ-021/022, out_code<=index+1, pending<=in_req minus selected bit, out_multi<=(popcount>1), enter DRAIN.
REQ-018 On accept with in_req==0: out_code<=0, out_last<=1, out_multi<=0, pending stays 0, enter DRAIN for one code.
REQ-019 In DRAIN with out_ready=1 and pending!=0: select next bit from pending, update out_code, clear that bit; out_last<=1 when resulting pending==0.
REQ-020 In DRAIN with out_ready=1, pending==0 and no accept: out_valid<=0, out_last<=0, return to IDLE; simultaneous accept reloads per REQ-017/018 with no bubble.
REQ-021 Fixed priority: lowest set index first (bit 0 -> code 1, bit N-1 -> code N).
REQ-022 Round-robin (REQ-027): search starts at index after last granted, wrapping N-1 -> 0; pointer persists across vectors.
REQ-023 SHALL hold out_code, out_last, out_multi stable while out_valid=1 and out_ready=0.
REQ-024 in_req changes while in_ready=0 SHALL be ignored; in_valid with in_ready=0 is not a loss, source holds.

Reset
REQ-025 rst=1 at a clock edge SHALL force pending=0, out_valid=0, out_code=0, out_last=0, out_multi=0, state IDLE, RR pointer=N-1 (first search starts at bit 0).
REQ-026 Reset mid-DRAIN SHALL discard remaining pending bits; in_ready=1 the cycle after rst deasserts.

Configuration
REQ-027 Macro ONEHOT_DRAIN_RR_EN defined: selection per REQ-022 with a registered last-grant pointer; undefined: selection per REQ-021, no pointer logic.
REQ-028 With ONEHOT_DRAIN_RR_EN undefined, output code order for any vector SHALL be strictly ascending.

Verification
REQ-029 N=15, fixed: in_req=15'h0004, out_ready=1 -> one code 3, out_last=1, out_multi=0, in_ready high next cycle.
REQ-030 N=15, fixed: in_req=15'h4005, out_ready=1 -> codes 1,3,15 on consecutive cycles, out_last only with 15, out_multi=1, in_ready low for 2 cycles.
REQ-031 in_req=15'h0000 -> single code 0 with out_last=1, then IDLE.
REQ-032 Backpressure: in_req=15'h0003, out_ready=0 for 5 cycles -> code 1 held stable, then codes 1,2 once out_ready=1.
REQ-033 RR_EN: vectors 15'h0003 then 15'h0003 back-to-back -> codes 1,2 then 1,2 (pointer wraps past 1 to search from 2,...,0); vector 15'h0006 after grant 2 -> codes 3... i.e. 2 granted last, next vector 15'h0006 yields 3 before 2.
REQ-034 rst asserted after first code of 15'h00F0 -> no further codes, out_valid=0, next vector 15'h0001 yields code 1.
